ddr_stream_buffer: RTL and testbench
====================================

Name: ddr_stream_buffer

Overview:
Local-interface initiator that drives the DDR2 controller's user side. It uses a window of DDR2 as a large circular FIFO between an upstream data stream (event words) and a downstream reader. Each word is written with a single-beat local write. Each word is fetched back with a single-beat local read. Returned data lands in a small on-chip output FIFO, because local_rdata_valid cannot be back-pressured. The block sits entirely in the controller's phy_clk domain.

Parameters:
ADDR_W, 24, width of local_address (word address).
DATA_W, 64, width of local_wdata/local_rdata (half-rate, 16-bit DDR2).
BE_W, 8, width of local_be (DATA_W/8).
BUF_BASE, 0, first DDR word address of the circular window.
BUF_WORDS, 2**20, window size in words; power of two, at most 2**ADDR_W - BUF_BASE.
OUT_DEPTH, 8, depth of the on-chip output FIFO; power of two, at least 4.

Ports:
phy_clk  in  1  controller user clock; all logic on rising edge
reset_phy_clk  in  1  asynchronous, active-high reset
local_init_done  in  1  controller calibration complete
local_ready  in  1  controller accepts the presented request this cycle
local_address  out  ADDR_W  word address of the request
local_write_req  out  1  write request
local_read_req  out  1  read request
local_burstbegin  out  1  first beat of a request
local_size  out  3  burst length; always 1
local_be  out  BE_W  byte enables; always all ones
local_wdata  out  DATA_W  write data
local_rdata  in  DATA_W  read data
local_rdata_valid  in  1  read data strobe
in_data  in  DATA_W  upstream word
in_valid  in  1  upstream word available
in_ready  out  1  upstream word accepted when in_valid & in_ready
out_data  out  DATA_W  head of the output FIFO
out_valid  out  1  output FIFO not empty
out_ready  in  1  pop when out_valid & out_ready
fill_level  out  ADDR_W+1  words stored in DDR that have not yet been read-requested
err_overrun  out  1  sticky; rdata_valid arrived while the output FIFO was full

Behaviour:
- Reset values: all outputs 0, including local_address, local_wdata, in_ready, out_valid, fill_level and err_overrun. Pointers, counts and the FSM are cleared. State is WAIT_INIT.
- Reset asserted mid-operation: all state is discarded immediately. In-flight controller reads are lost. The integrator resets the controller together with this block.
- FSM states:
  - WAIT_INIT -> IDLE when local_init_done=1.
  - IDLE: decision each cycle, read has priority:
    - Choose read if fill_level>0 and credit>0, where credit = OUT_DEPTH - out_count - outstanding.
    - Else, if in_valid=1 and fill_level+1 < BUF_WORDS + 1, assert in_ready for exactly this cycle. Capture in_data into local_wdata and go to WRITE.
    - in_ready is 1 only in IDLE, only when no read is chosen, and only when fill_level < BUF_WORDS.
  - WRITE:
    - local_write_req=1, local_burstbegin=1, local_address=BUF_BASE+wr_ptr.
    - Outputs are held stable until a cycle with local_ready=1.
    - In that cycle: wr_ptr <= (wr_ptr+1) mod BUF_WORDS, fill_level +1, next state IDLE.
  - READ:
    - local_read_req=1, local_burstbegin=1, local_address=BUF_BASE+rd_ptr.
    - Outputs are held until local_ready=1.
    - In that cycle: rd_ptr wraps mod BUF_WORDS, fill_level -1, outstanding +1, next state IDLE.
- Request timing:
  - At most one request per two cycles, because IDLE always sits between requests.
  - write_req and read_req are never both 1.
  - burstbegin equals (write_req | read_req).
- local_size=1 and local_be all ones whenever a request is asserted.
- Read return: each local_rdata_valid pushes local_rdata into the output FIFO and decrements outstanding.
  - Data order equals request order, so FIFO ordering holds.
  - If the output FIFO is full: data is dropped, err_overrun is set to 1 until reset, and outstanding still decrements. The credit rule makes this unreachable under a compliant controller.
- Output FIFO:
  - out_valid/out_data come from registers.
  - A push and pop in the same cycle leaves out_count unchanged.
  - A pop from empty is ignored.
- fill_level:
  - Range 0..BUF_WORDS.
  - Write accept and read accept never coincide.
  - The full condition (fill_level==BUF_WORDS) blocks in_ready. The empty condition blocks reads.
- Latency: first in_data word appears on out_data at least 4 cycles after acceptance plus the controller read latency.

Test Plan:
1. Hold local_init_done=0 for 50 cycles with in_valid=1 -> in_ready, write_req and read_req all stay 0. After local_init_done=1, the first write is issued at address BUF_BASE.
2. BUF_WORDS=16: push 5 words 0x1..0x5 with out_ready=1 and a controller model with read latency 6 and always-ready -> out_data yields 0x1..0x5 in order, fill_level returns to 0, err_overrun=0.
3. BUF_WORDS=16, out_ready=0: push 24 words -> 8 are read back into the output FIFO, 16 remain in DDR, fill_level=16, in_ready=0. Raise out_ready -> all 24 words drain in order. wr_ptr and rd_ptr wrap from 15 to 0 with local_address=BUF_BASE+0.
4. Controller drops local_ready to 0 for 7 cycles during a WRITE -> local_address, local_wdata and write_req are held constant. Exactly one write is accepted, and fill_level increments once.
5. Force local_rdata_valid with the output FIFO full (OUT_DEPTH=8, out_ready=0, rogue controller) -> err_overrun=1 and stays 1. Apply reset_phy_clk mid-WRITE -> all outputs 0 asynchronously, err_overrun=0, state WAIT_INIT.

Source files
------------

// File: rtl/ddr_stream_buffer.sv
// ddr_stream_buffer: uses a window of DDR2 as a large circular FIFO between an
// upstream word stream and a downstream reader, driving the controller's local
// (user-side) interface with single-beat writes and reads.
// Latency: a word reaches out_data >= 4 cycles after acceptance plus controller read latency.
// Backpressure: in_ready drops when the DDR window is full or a read is being issued;
//   reads are only issued while the output FIFO has credit, since rdata_valid cannot stall.
// Ports: phy_clk/reset_phy_clk (async, active high); local_* controller user interface;
//   in_data/in_valid/in_ready upstream; out_data/out_valid/out_ready downstream;
//   fill_level = words held in DDR not yet read-requested; err_overrun sticky drop flag.
module ddr_stream_buffer #(
  parameter int          ADDR_W    = 24,
  parameter int          DATA_W    = 64,
  parameter int          BE_W      = 8,
  parameter int unsigned BUF_BASE  = 0,
  parameter int unsigned BUF_WORDS = 2**20,
  parameter int unsigned OUT_DEPTH = 8
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk,
  input  logic              local_init_done,
  input  logic              local_ready,
  output logic [ADDR_W-1:0] local_address,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic              local_burstbegin,
  output logic [2:0]        local_size,
  output logic [BE_W-1:0]   local_be,
  output logic [DATA_W-1:0] local_wdata,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   fill_level,
  output logic              err_overrun
);

  localparam int PTR_W = $clog2(BUF_WORDS);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(BUF_WORDS);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BUF_BASE);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(OUT_DEPTH);

  typedef enum logic [1:0] {WAIT_INIT, IDLE, WRITE, READ} state_t;

  state_t            state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  out_count;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  out_count_nxt;
  logic [CNT_W-1:0]  push_idx;
  logic [CNT_W:0]    committed;
  logic [DATA_W-1:0] mem [OUT_DEPTH];
  logic              rd_go;
  logic              rd_acc;
  logic              fifo_full;
  logic              push;
  logic              pop;

  // Every output slot is either occupied or promised to a read in flight;
  // a new read may only be issued while some slot is still unpromised.
  assign committed = {1'b0, out_count} + {1'b0, outstanding};
  assign rd_go     = (state == IDLE) && (fill_level != '0) && (committed < {1'b0, DEPTH_C});
  assign in_ready  = (state == IDLE) && !rd_go && (fill_level < FULL_LVL);
  assign rd_acc    = (state == READ) && local_ready;

  assign local_size = {2'b00, local_burstbegin};
  assign local_be   = {BE_W{local_burstbegin}};

  always_ff @(posedge phy_clk or posedge reset_phy_clk) begin
    if (reset_phy_clk) begin
      state            <= WAIT_INIT;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fill_level       <= '0;
      local_write_req  <= 1'b0;
      local_read_req   <= 1'b0;
      local_burstbegin <= 1'b0;
      local_address    <= '0;
      local_wdata      <= '0;
    end else begin
      case (state)
        WAIT_INIT: if (local_init_done) state <= IDLE;
        IDLE: begin
          if (rd_go) begin
            state            <= READ;
            local_read_req   <= 1'b1;
            local_burstbegin <= 1'b1;
            local_address    <= BASE_A + ADDR_W'(rd_ptr);
          end else if (in_valid && in_ready) begin
            state            <= WRITE;
            local_write_req  <= 1'b1;
            local_burstbegin <= 1'b1;
            local_address    <= BASE_A + ADDR_W'(wr_ptr);
            local_wdata      <= in_data;
          end
        end
        WRITE: if (local_ready) begin
          state            <= IDLE;
          local_write_req  <= 1'b0;
          local_burstbegin <= 1'b0;
          wr_ptr           <= wr_ptr + 1'b1;   // window is a power of two: wraps naturally
          fill_level       <= fill_level + 1'b1;
        end
        READ: if (local_ready) begin
          state            <= IDLE;
          local_read_req   <= 1'b0;
          local_burstbegin <= 1'b0;
          rd_ptr           <= rd_ptr + 1'b1;
          fill_level       <= fill_level - 1'b1;
        end
        default: state <= WAIT_INIT;
      endcase
    end
  end

  // Output FIFO is a shift register so the head (out_data) is always slot 0.
  assign fifo_full = (out_count == DEPTH_C);
  assign push      = local_rdata_valid && !fifo_full;
  assign pop       = out_valid && out_ready;
  assign push_idx  = pop ? out_count - 1'b1 : out_count;
  assign out_data  = mem[0];

  always_comb begin
    out_count_nxt = out_count;
    case ({push, pop})
      2'b10:   out_count_nxt = out_count + 1'b1;
      2'b01:   out_count_nxt = out_count - 1'b1;
      default: out_count_nxt = out_count;
    endcase
  end

  always_ff @(posedge phy_clk or posedge reset_phy_clk) begin
    if (reset_phy_clk) begin
      out_count   <= '0;
      outstanding <= '0;
      out_valid   <= 1'b0;
      err_overrun <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        if (push && (CNT_W'(i) == push_idx)) mem[i] <= local_rdata;
        else if (pop) mem[i] <= mem[(i < OUT_DEPTH-1) ? i+1 : i];
      end
      out_count <= out_count_nxt;
      out_valid <= (out_count_nxt != '0);
      // A stray strobe with nothing outstanding must not wrap the counter and
      // lock out all future reads.
      case ({rd_acc, local_rdata_valid && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (local_rdata_valid && fifo_full) err_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_stream_buffer.sv
// Testbench for ddr_stream_buffer: directed phases plus a randomized phase, with a
// DDR controller model (memory + in-order read returns) and a word-order scoreboard.
module tb_ddr_stream_buffer;
  localparam int AW = 24, DW = 64, BW = 8, BASE = 'h100, WORDS = 16, DEPTH = 8;

  logic          phy_clk = 1'b0;
  logic          reset_phy_clk, local_init_done, local_ready;
  logic [AW-1:0] local_address;
  logic          local_write_req, local_read_req, local_burstbegin;
  logic [2:0]    local_size;
  logic [BW-1:0] local_be;
  logic [DW-1:0] local_wdata, local_rdata, in_data, out_data;
  logic          local_rdata_valid, in_valid, in_ready, out_valid, out_ready;
  logic [AW:0]   fill_level;
  logic          err_overrun;

  ddr_stream_buffer #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .BUF_BASE(BASE),
                      .BUF_WORDS(WORDS), .OUT_DEPTH(DEPTH)) dut (
    .phy_clk(phy_clk), .reset_phy_clk(reset_phy_clk), .local_init_done(local_init_done),
    .local_ready(local_ready), .local_address(local_address), .local_write_req(local_write_req),
    .local_read_req(local_read_req), .local_burstbegin(local_burstbegin), .local_size(local_size),
    .local_be(local_be), .local_wdata(local_wdata), .local_rdata(local_rdata),
    .local_rdata_valid(local_rdata_valid), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .err_overrun(err_overrun));

  always #5 phy_clk = ~phy_clk;

  typedef struct { logic [63:0] d; int due; } rret_t;

  int n_chk, n_pass, n_fail;
  int cyc, last_due, lat_min, lat_max;
  int n_wr, n_rd, n_out, rd0, nwr0;
  bit ready_en, out_en, rnd_mode, rogue;
  logic [63:0] src_q[$], exp_q[$], wexp_q[$];
  rret_t       rq[$];
  logic [63:0] ddr [int];
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;
  logic [AW:0]   fill0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wreq"}, 64'(local_write_req), 0);
    chk({tag, "_rreq"}, 64'(local_read_req), 0);
    chk({tag, "_bb"}, 64'(local_burstbegin), 0);
    chk({tag, "_addr"}, 64'(local_address), 0);
    chk({tag, "_wdata"}, local_wdata, 0);
    chk({tag, "_size"}, 64'(local_size), 0);
    chk({tag, "_be"}, 64'(local_be), 0);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_fill"}, 64'(fill_level), 0);
    chk({tag, "_err"}, 64'(err_overrun), 0);
  endtask

  // One clock cycle: drive inputs for the coming edge, check, account for handshakes.
  task automatic tick();
    int due;
    in_valid    = (src_q.size() > 0) && (!rnd_mode || $urandom_range(0, 3) != 0);
    in_data     = (src_q.size() > 0) ? src_q[0] : '0;
    local_ready = ready_en && (!rnd_mode || $urandom_range(0, 3) != 0);
    out_ready   = out_en && (!rnd_mode || $urandom_range(0, 2) != 0);
    local_rdata_valid = 1'b0;
    local_rdata       = '0;
    if (rogue) begin
      local_rdata_valid = 1'b1;
      local_rdata       = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      local_rdata_valid = 1'b1;
      local_rdata       = rq[0].d;
      void'(rq.pop_front());
    end
    #1;
    chk("fill_model", 64'(fill_level), 64'(n_wr - n_rd));
    chk("req_excl", 64'(local_write_req & local_read_req), 0);
    chk("burstbegin", 64'(local_burstbegin), 64'(local_write_req | local_read_req));
    if (local_write_req || local_read_req) begin
      chk("size", 64'(local_size), 1);
      chk("be", 64'(local_be), 64'hFF);
    end
    if (in_ready) chk("in_ready_full", 64'(fill_level < WORDS), 1);
    if (in_valid && in_ready) begin
      exp_q.push_back(in_data);
      wexp_q.push_back(in_data);
      void'(src_q.pop_front());
    end
    if (local_write_req && local_ready) begin
      chk("wr_addr", 64'(local_address), 64'(BASE + (n_wr % WORDS)));
      if (wexp_q.size() > 0) chk("wr_data", local_wdata, wexp_q.pop_front());
      else chk("wr_extra", 64'(local_write_req), 0);
      ddr[int'(local_address)] = local_wdata;
      n_wr++;
    end
    if (local_read_req && local_ready) begin
      chk("rd_addr", 64'(local_address), 64'(BASE + (n_rd % WORDS)));
      due = cyc + int'($urandom_range(lat_min, lat_max));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq.push_back('{ddr.exists(int'(local_address)) ? ddr[int'(local_address)] : 64'hx, due});
      n_rd++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
      else chk("out_extra", 64'(out_valid), 0);
      n_out++;
    end
    @(posedge phy_clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && (src_q.size() + exp_q.size() + rq.size()) > 0; i++) tick();
    chk({tag, "_drained"}, 64'(src_q.size() + exp_q.size() + rq.size()), 0);
    repeat (4) tick();
  endtask

  initial begin
    reset_phy_clk = 1'b1; local_init_done = 1'b0; local_ready = 1'b0;
    local_rdata = '0; local_rdata_valid = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    ready_en = 1; out_en = 0; rnd_mode = 0; rogue = 0; lat_min = 6; lat_max = 6;
    repeat (3) @(posedge phy_clk);
    #1;
    chk_all_zero("reset");
    reset_phy_clk = 1'b0;

    // Calibration not done: nothing moves even with a word offered.
    src_q.push_back(64'h1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("pre_init", 64'({in_ready, local_write_req, local_read_req}), 0);
    end
    local_init_done = 1'b1;
    out_en = 1;
    for (int i = 0; i < 10 && !local_write_req; i++) tick();
    chk("first_wr_vld", 64'(local_write_req), 1);
    chk("first_wr_addr", 64'(local_address), 64'(BASE));

    // Five words round-trip in order.
    for (int w = 2; w <= 5; w++) src_q.push_back(64'(w));
    drain("five", 500);
    chk("five_count", 64'(n_out), 5);
    chk("five_fill", 64'(fill_level), 0);
    chk("five_err", 64'(err_overrun), 0);

    // Downstream stalled: output FIFO fills, DDR window fills, then drain with wrap.
    out_en = 0; n_out = 0; rd0 = n_rd;
    for (int w = 0; w < 24; w++) src_q.push_back({$urandom, $urandom});
    repeat (300) tick();
    chk("full_fill", 64'(fill_level), WORDS);
    chk("full_in_ready", 64'(in_ready), 0);
    chk("full_out_valid", 64'(out_valid), 1);
    chk("full_src_left", 64'(src_q.size()), 0);
    chk("full_reads", 64'(n_rd - rd0), DEPTH);
    out_en = 1;
    drain("full", 2000);
    chk("full_count", 64'(n_out), 24);
    chk("full_fill_end", 64'(fill_level), 0);

    // Randomized traffic, random controller stalls and read latency.
    rnd_mode = 1; lat_min = 3; lat_max = 10; n_out = 0;
    for (int w = 0; w < 150; w++) src_q.push_back({$urandom, $urandom});
    drain("rand", 8000);
    chk("rand_count", 64'(n_out), 150);
    chk("rand_fill", 64'(fill_level), 0);
    chk("rand_err", 64'(err_overrun), 0);
    rnd_mode = 0; lat_min = 6; lat_max = 6;

    // Controller holds local_ready low for 7 cycles during a WRITE.
    ready_en = 0;
    src_q.push_back(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 10 && !local_write_req; i++) tick();
    chk("stall_wr_vld", 64'(local_write_req), 1);
    hold_addr = local_address; hold_data = local_wdata; fill0 = fill_level; nwr0 = n_wr;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stall_wreq", 64'(local_write_req), 1);
      chk("stall_addr", 64'(local_address), 64'(hold_addr));
      chk("stall_wdata", local_wdata, hold_data);
    end
    ready_en = 1;
    tick();
    chk("stall_released", 64'(local_write_req), 0);
    chk("stall_fill", 64'(fill_level), 64'(fill0 + 1));
    chk("stall_one_wr", 64'(n_wr - nwr0), 1);
    drain("stall", 500);

    // Rogue read strobe with the output FIFO full.
    out_en = 0; n_out = 0;
    for (int w = 0; w < DEPTH; w++) src_q.push_back(64'hF000 + 64'(w));
    repeat (200) tick();
    chk("ovr_pre_valid", 64'(out_valid), 1);
    chk("ovr_pre_err", 64'(err_overrun), 0);
    rogue = 1;
    tick();
    rogue = 0;
    chk("ovr_err", 64'(err_overrun), 1);
    repeat (10) tick();
    chk("ovr_err_sticky", 64'(err_overrun), 1);
    out_en = 1;
    drain("ovr", 500);
    chk("ovr_count", 64'(n_out), DEPTH);
    chk("ovr_err_end", 64'(err_overrun), 1);

    // Asynchronous reset in the middle of a stalled WRITE.
    ready_en = 0;
    src_q.push_back(64'hCAFE);
    for (int i = 0; i < 10 && !local_write_req; i++) tick();
    chk("rst_wr_vld", 64'(local_write_req), 1);
    #2;
    reset_phy_clk = 1'b1;
    #1;
    chk_all_zero("async_rst");
    local_init_done = 1'b0;
    src_q.delete(); exp_q.delete(); wexp_q.delete(); rq.delete(); ddr.delete();
    n_wr = 0; n_rd = 0; n_out = 0; last_due = cyc;
    repeat (2) @(posedge phy_clk);
    #1;
    reset_phy_clk = 1'b0;
    ready_en = 1;
    src_q.push_back(64'hA5A5_5A5A);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_wait", 64'({in_ready, local_write_req, local_read_req}), 0);
    end
    local_init_done = 1'b1;
    drain("post_rst", 500);
    chk("post_rst_count", 64'(n_out), 1);
    chk("post_rst_err", 64'(err_overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
